// File: rtl/switch_scan_ctrl_if.sv
// switch_scan_ctrl_if: CPU register bus (cs/addr/read/write/wdata -> rdata); master = CPU, slave = switch_scan_ctrl
interface switch_scan_ctrl_if;
  logic switchcs;
  logic [1:0] switchaddr;
  logic switchread;
  logic switchwrite;
  logic [15:0] switchwdata;
  logic [15:0] switchrdata;
  modport master(output switchcs, switchaddr, switchread, switchwrite, switchwdata, input switchrdata);
  modport slave(input switchcs, switchaddr, switchread, switchwrite, switchwdata, output switchrdata);
endinterface

// File: rtl/switch_scan_ctrl.sv
// switch_scan_ctrl: debounces 24 board switches; ports switclk/switrst, bus (slave register port), switch_i raw in, switch_stable debounced out, switch_irq change interrupt; macro SWITCH_IRQ_EN enables the change register and irq
module switch_scan_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int STABLE_TICKS = 10
) (
  input logic switclk,
  input logic switrst,
  switch_scan_ctrl_if.slave bus,
  input logic [23:0] switch_i,
  output logic [23:0] switch_stable,
  output logic switch_irq
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT} state_t;
  state_t state;
  logic [23:0] s1, sync, candidate, change;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] count;
  logic [CW:0] count_nxt;
  logic tick, rd, wr;
  logic [15:0] rd_mux;
  assign tick = tcnt == TW'(TICK_DIV - 1);
  assign count_nxt = {1'b0, count} + 1'b1;
  assign rd = bus.switchcs && bus.switchread;
  assign wr = bus.switchcs && bus.switchwrite;
  always_ff @(posedge switclk or posedge switrst)
    if (switrst) begin
      s1 <= '0;
      sync <= '0;
      tcnt <= '0;
    end else begin
      s1 <= switch_i;
      sync <= s1;
      tcnt <= tick ? '0 : tcnt + 1'b1;
    end
  always_ff @(posedge switclk or posedge switrst)
    if (switrst) begin
      state <= IDLE;
      candidate <= '0;
      count <= '0;
      switch_stable <= '0;
    end else
      case (state)
        IDLE:
          if (tick && sync != switch_stable) begin
            candidate <= sync;
            count <= '0;
            state <= SETTLE;
          end
        SETTLE:
          if (tick) begin
            if (sync != candidate) begin
              candidate <= sync;
              count <= '0;
              // input bounced back to the accepted value: abandon without commit
              state <= sync == switch_stable ? IDLE : SETTLE;
            end else if (count_nxt == (CW + 1)'(STABLE_TICKS))
              state <= COMMIT;
            else
              count <= count_nxt[CW-1:0];
          end
        COMMIT: begin
          switch_stable <= candidate;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef SWITCH_IRQ_EN
  logic [23:0] clr;
  assign clr = !wr ? '0 : bus.switchaddr == 2'b01 ? {8'd0, bus.switchwdata} : bus.switchaddr == 2'b11 ? {bus.switchwdata[7:0], 16'd0} : '0;
  // set is OR-ed after the clear so a same-cycle commit wins over W1C
  always_ff @(posedge switclk or posedge switrst)
    if (switrst) change <= '0;
    else change <= (change & ~clr) | (state == COMMIT ? switch_stable ^ candidate : '0);
`else
  logic unused;
  assign unused = ^{wr, bus.switchwdata};
  assign change = '0;
`endif
  assign switch_irq = |change;
  assign rd_mux = bus.switchaddr[0] ? (bus.switchaddr[1] ? {8'd0, change[23:16]} : change[15:0]) : (bus.switchaddr[1] ? {8'd0, switch_stable[23:16]} : switch_stable[15:0]);
  always_ff @(posedge switclk or posedge switrst)
    if (switrst) bus.switchrdata <= '0;
    else if (rd) bus.switchrdata <= rd_mux;
endmodule

// File: tb/tb_switch_scan_ctrl.sv
// tb_switch_scan_ctrl: scoreboard bench for switch_scan_ctrl with TICK_DIV=4, STABLE_TICKS=3
module tb_switch_scan_ctrl;
`ifdef SWITCH_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] sw_in = '0;
  logic [23:0] stable;
  logic irq;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  string name_q[$];
  logic [15:0] m_exp;
  string m_name;
  switch_scan_ctrl_if bus();
  switch_scan_ctrl #(.TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .switclk(clk),
    .switrst(rst),
    .bus(bus),
    .switch_i(sw_in),
    .switch_stable(stable),
    .switch_irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  always begin
    @(posedge clk);
    if (!rst && bus.switchcs && bus.switchread) begin
      #1;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read_unexpected got=%h (no expectation queued)", bus.switchrdata);
      end else begin
        m_exp = exp_q.pop_front();
        m_name = name_q.pop_front();
        if (bus.switchrdata !== m_exp) begin
          fails++;
          $display("FAIL %s got=%h exp=%h", m_name, bus.switchrdata, m_exp);
        end
      end
    end
  end
  task automatic check(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic rd(logic [1:0] a, logic [15:0] e, string n);
    @(negedge clk);
    bus.switchcs = 1'b1;
    bus.switchread = 1'b1;
    bus.switchaddr = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    bus.switchcs = 1'b0;
    bus.switchread = 1'b0;
  endtask
  task automatic wr(logic [1:0] a, logic [15:0] d);
    @(negedge clk);
    bus.switchcs = 1'b1;
    bus.switchwrite = 1'b1;
    bus.switchaddr = a;
    bus.switchwdata = d;
    @(negedge clk);
    bus.switchcs = 1'b0;
    bus.switchwrite = 1'b0;
  endtask
  task automatic rw(logic [1:0] a, logic [15:0] d, logic [15:0] e, string n);
    @(negedge clk);
    bus.switchcs = 1'b1;
    bus.switchread = 1'b1;
    bus.switchwrite = 1'b1;
    bus.switchaddr = a;
    bus.switchwdata = d;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    bus.switchcs = 1'b0;
    bus.switchread = 1'b0;
    bus.switchwrite = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_stable(logic [23:0] v, string n);
    for (int i = 0; i < 40 && stable !== v; i++) @(negedge clk);
    check(n, stable, v);
  endtask
  task automatic wait_cyc(int c);
    while (cyc < c) @(negedge clk);
  endtask
  initial begin
    bus.switchcs = 1'b0;
    bus.switchread = 1'b0;
    bus.switchwrite = 1'b0;
    bus.switchaddr = 2'b00;
    bus.switchwdata = '0;
    do_reset();
    check("rst_stable", stable, 24'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_rdata", bus.switchrdata, 16'h0);
    rd(2'b00, 16'h0000, "rst_rd00");
    rd(2'b01, 16'h0000, "rst_rd01");
    sw_in = 24'hA50F3C;
    wait_stable(24'hA50F3C, "stable_a50f3c");
    rd(2'b00, 16'h0F3C, "rd00_a5");
    rd(2'b10, 16'h00A5, "rd10_a5");
    check("irq_after_commit", irq, IRQ);
    rd(2'b01, IRQ ? 16'h0F3C : 16'h0000, "rd01_change");
    rd(2'b11, IRQ ? 16'h00A5 : 16'h0000, "rd11_change");
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.switchrdata, IRQ ? 16'h00A5 : 16'h0000);
    rw(2'b01, 16'h0F3C, IRQ ? 16'h0F3C : 16'h0000, "rw_prewrite");
    rd(2'b01, 16'h0000, "rd01_cleared");
    check("irq_before_hi_clear", irq, IRQ);
    wr(2'b11, 16'h00A5);
    check("irq_after_clear", irq, 1'b0);
    rd(2'b11, 16'h0000, "rd11_cleared");
    wr(2'b00, 16'hFFFF);
    rd(2'b00, 16'h0F3C, "wr00_ignored");
    do_reset();
    for (int i = 0; i < 40; i++) begin
      sw_in = {23'd0, ((cyc + 1) % 4) < 2};
      @(negedge clk);
    end
    sw_in = '0;
    repeat (20) @(negedge clk);
    check("bounce_stable", stable, 24'h0);
    check("bounce_irq", irq, 1'b0);
    rd(2'b01, 16'h0000, "bounce_change");
    do_reset();
    sw_in = 24'h000002;
    wait_cyc(8);
    sw_in = '0;
    repeat (30) @(negedge clk);
    check("bounce_back_stable", stable, 24'h0);
    rd(2'b01, 16'h0000, "bounce_back_change");
    do_reset();
    sw_in = 24'h000010;
    wait_cyc(16);
    check("pre_commit_stable", stable, 24'h0);
    bus.switchcs = 1'b1;
    bus.switchwrite = 1'b1;
    bus.switchaddr = 2'b01;
    bus.switchwdata = 16'h0010;
    @(negedge clk);
    bus.switchcs = 1'b0;
    bus.switchwrite = 1'b0;
    check("commit_cycle_stable", stable, 24'h000010);
    rd(2'b01, IRQ ? 16'h0010 : 16'h0000, "set_wins");
    check("set_wins_irq", irq, IRQ);
    do_reset();
    sw_in = 24'hFFFFFF;
    wait_cyc(10);
    rst = 1'b1;
    #1;
    check("mid_settle_rst_stable", stable, 24'h0);
    check("mid_settle_rst_irq", irq, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_partial_commit", stable, 24'h0);
    wait_stable(24'hFFFFFF, "redebounce_ffffff");
    rd(2'b01, IRQ ? 16'hFFFF : 16'h0000, "redebounce_chg_lo");
    rd(2'b11, IRQ ? 16'h00FF : 16'h0000, "redebounce_chg_hi");
    rd(2'b10, 16'h00FF, "redebounce_rd10");
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
